regfile_mp: RTL and testbench

- Parametrised multi-port register file for the pipelined MIPS core and follow-on wider and dual-issue datapaths.
- Provides NR registered read ports and NW write ports with per-byte write enables.
- Includes optional same-cycle write-to-read bypass and per-port read-enable hold for pipeline stalls.
- Register 0 can be hardwired to zero; with default parameters it serves as a drop-in register file for the decode stage.

---
 rtl/regfile_mp_pkg.sv | 18 +
 rtl/regfile_wmerge.sv | 35 +++
 rtl/regfile_mp.sv | 110 +++++++++++
 tb/tb_regfile_mp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Default geometry matches the pipelined MIPS decode-stage register file.
package regfile_mp_pkg;

    localparam int RF_DW       = 32;
    localparam int RF_AW       = 5;
    localparam int RF_DEPTH    = 32;
    localparam int RF_NR       = 2;
    localparam int RF_NW       = 1;
    localparam int RF_ZERO_REG = 1;
    localparam int RF_BYPASS   = 1;

    // Number of byte lanes in a word of width dw.
    function automatic int rf_nbytes(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/regfile_wmerge.sv
// Per-byte merge of all write ports into one entry value.
// Later (higher-indexed) ports overwrite earlier ones, so the highest index wins per byte.
module regfile_wmerge
    import regfile_mp_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW,
    parameter int NW = RF_NW
)
(
    input  logic [DW-1:0]               cur,
    input  logic [AW-1:0]               addr,
    input  logic [NW-1:0]               wen,
    input  logic [NW*AW-1:0]            waddr,
    input  logic [NW*DW-1:0]            wdata,
    input  logic [NW*rf_nbytes(DW)-1:0] wbe,
    output logic [DW-1:0]               nxt
);

    localparam int NB = rf_nbytes(DW);

    always_comb begin
        nxt = cur;
        for (int j = 0; j < NW; j++) begin
            if (wen[j] && (waddr[j*AW +: AW] == addr)) begin
                for (int b = 0; b < NB; b++) begin
                    if (wbe[j*NB + b]) begin
                        nxt[b*8 +: 8] = wdata[j*DW + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NR registered read ports, NW byte-enabled write ports,
// optional hardwired zero entry and same-cycle write-to-read bypass.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int AW       = RF_AW,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NR       = RF_NR,
    parameter int NW       = RF_NW,
    parameter int ZERO_REG = RF_ZERO_REG,
    parameter int BYPASS   = RF_BYPASS
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NR-1:0]               ren,
    input  logic [NR*AW-1:0]            raddr,
    output logic [NR*DW-1:0]            rdata,
    input  logic [NW-1:0]               wen,
    input  logic [NW*AW-1:0]            waddr,
    input  logic [NW*DW-1:0]            wdata,
    input  logic [NW*rf_nbytes(DW)-1:0] wbe
);

    logic [DW-1:0] mem      [DEPTH];
    logic [DW-1:0] mem_nxt  [DEPTH];
    logic [DW-1:0] rd_val   [NR];
    logic [DW-1:0] rdata_p1 [NR];

    // Next value of every entry; out-of-range write addresses never match an entry index.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        if ((ZERO_REG != 0) && (e == 0)) begin : g_zero
            assign mem_nxt[e] = '0;
        end else begin : g_live
            regfile_wmerge #(
                .DW (DW),
                .AW (AW),
                .NW (NW)
            ) u_merge (
                .cur   (mem[e]),
                .addr  (AW'(e)),
                .wen   (wen),
                .waddr (waddr),
                .wdata (wdata),
                .wbe   (wbe),
                .nxt   (mem_nxt[e])
            );
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (!rst) begin
                mem[e] <= '0;
            end else begin
                mem[e] <= mem_nxt[e];
            end
        end
    end

    // Read value per port; the bypass merge reuses the array's priority logic.
    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          in_range;
        logic          is_zero;
        logic [DW-1:0] cur;

        assign ra       = raddr[i*AW +: AW];
        assign in_range = ({1'b0, ra} < (AW+1)'(DEPTH));
        assign is_zero  = (ZERO_REG != 0) && (ra == '0);
        assign cur      = in_range ? mem[ra] : '0;

        if (BYPASS != 0) begin : g_byp
            logic [DW-1:0] merged;

            regfile_wmerge #(
                .DW (DW),
                .AW (AW),
                .NW (NW)
            ) u_byp (
                .cur   (cur),
                .addr  (ra),
                .wen   (wen),
                .waddr (waddr),
                .wdata (wdata),
                .wbe   (wbe),
                .nxt   (merged)
            );

            assign rd_val[i] = (is_zero || !in_range) ? '0 : merged;
        end else begin : g_old
            assign rd_val[i] = (is_zero || !in_range) ? '0 : cur;
        end

        assign rdata[i*DW +: DW] = rdata_p1[i];
    end

    // p1: registered read data, held while ren is low
    always_ff @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (!rst) begin
                rdata_p1[i] <= '0;
            end else if (ren[i]) begin
                rdata_p1[i] <= rd_val[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a dual-write bypassing build (A) and a
// single-write, no-zero, no-bypass, 24-entry build (B) run side by side.
module tb_regfile_mp;

    logic        clk;
    logic        rst;

    logic [1:0]  ren_a;
    logic [9:0]  raddr_a;
    logic [63:0] rdata_a;
    logic [1:0]  wen_a;
    logic [9:0]  waddr_a;
    logic [63:0] wdata_a;
    logic [7:0]  wbe_a;

    logic [1:0]  ren_b;
    logic [9:0]  raddr_b;
    logic [63:0] rdata_b;
    logic [0:0]  wen_b;
    logic [4:0]  waddr_b;
    logic [31:0] wdata_b;
    logic [3:0]  wbe_b;

    int vectors;
    int miscompares;

    logic [31:0] ma [32];
    logic [31:0] mb [24];
    logic [63:0] rda, rdb;
    logic [63:0] q_a [$];
    logic [63:0] q_b [$];

    regfile_mp #(
        .DW(32), .AW(5), .DEPTH(32), .NR(2), .NW(2), .ZERO_REG(1), .BYPASS(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .ren(ren_a), .raddr(raddr_a), .rdata(rdata_a),
        .wen(wen_a), .waddr(waddr_a), .wdata(wdata_a), .wbe(wbe_a)
    );

    regfile_mp #(
        .DW(32), .AW(5), .DEPTH(24), .NR(2), .NW(1), .ZERO_REG(0), .BYPASS(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .ren(ren_b), .raddr(raddr_b), .rdata(rdata_b),
        .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b), .wbe(wbe_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wen_a = '0; wbe_a = '0; ren_a = '0;
        wen_b = '0; wbe_b = '0; ren_b = '0;
    endtask

    task automatic wr_a(input int p, input logic [4:0] ad, input logic [31:0] d, input logic [3:0] be);
        wen_a[p] = 1'b1;
        waddr_a[p*5 +: 5] = ad;
        wdata_a[p*32 +: 32] = d;
        wbe_a[p*4 +: 4] = be;
    endtask

    task automatic wr_b(input logic [4:0] ad, input logic [31:0] d, input logic [3:0] be);
        wen_b = 1'b1;
        waddr_b = ad;
        wdata_b = d;
        wbe_b = be;
    endtask

    task automatic rd(input int p, input logic [4:0] ad);
        ren_a[p] = 1'b1; raddr_a[p*5 +: 5] = ad;
        ren_b[p] = 1'b1; raddr_b[p*5 +: 5] = ad;
    endtask

    // Predict the post-edge state from the current inputs, clock once, compare.
    task automatic tick(input string tag);
        logic [31:0] na [32];
        logic [31:0] nb [24];
        logic [63:0] ea, eb, xa, xb;
        int a;
        na = ma;
        nb = mb;
        ea = rda;
        eb = rdb;
        if (!rst) begin
            foreach (na[e]) na[e] = '0;
            foreach (nb[e]) nb[e] = '0;
            ea = '0;
            eb = '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (wen_a[j]) begin
                    a = int'(waddr_a[j*5 +: 5]);
                    for (int b = 0; b < 4; b++)
                        if (a != 0 && wbe_a[j*4 + b]) na[a][b*8 +: 8] = wdata_a[j*32 + b*8 +: 8];
                end
            end
            if (wen_b[0]) begin
                a = int'(waddr_b);
                for (int b = 0; b < 4; b++)
                    if (a < 24 && wbe_b[b]) nb[a][b*8 +: 8] = wdata_b[b*8 +: 8];
            end
            for (int i = 0; i < 2; i++) begin
                if (ren_a[i]) begin
                    a = int'(raddr_a[i*5 +: 5]);
                    ea[i*32 +: 32] = (a == 0) ? 32'h0 : na[a];
                end
                if (ren_b[i]) begin
                    a = int'(raddr_b[i*5 +: 5]);
                    eb[i*32 +: 32] = (a < 24) ? mb[a] : 32'h0;
                end
            end
        end
        ma = na;
        mb = nb;
        rda = ea;
        rdb = eb;
        q_a.push_back(ea);
        q_b.push_back(eb);
        @(posedge clk);
        #1;
        xa = q_a.pop_front();
        xb = q_b.pop_front();
        check_eq({tag, "/a0"}, rdata_a[31:0],  xa[31:0]);
        check_eq({tag, "/a1"}, rdata_a[63:32], xa[63:32]);
        check_eq({tag, "/b0"}, rdata_b[31:0],  xb[31:0]);
        check_eq({tag, "/b1"}, rdata_b[63:32], xb[63:32]);
    endtask

    task automatic sweep(input string tag);
        for (int k = 0; k < 32; k += 2) begin
            idle();
            rd(0, 5'(k));
            rd(1, 5'(k + 1));
            tick(tag);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rda = '0;
        rdb = '0;
        foreach (ma[e]) ma[e] = '0;
        foreach (mb[e]) mb[e] = '0;
        raddr_a = '0; waddr_a = '0; wdata_a = '0;
        raddr_b = '0; waddr_b = '0; wdata_b = '0;
        idle();
        rst = 1'b0;
        tick("reset0");
        tick("reset1");

        // reset overrides a write and a read in the same edge
        rst = 1'b1;
        wr_a(0, 5'd5, 32'hDEADBEEF, 4'hF);
        wr_b(5'd5, 32'hDEADBEEF, 4'hF);
        tick("pre_rst_wr");
        idle();
        rst = 1'b0;
        wr_a(0, 5'd6, 32'h00001234, 4'hF);
        wr_b(5'd6, 32'h00001234, 4'hF);
        rd(0, 5'd5);
        tick("rst_wr");
        rst = 1'b1;
        idle();
        rd(0, 5'd5);
        rd(1, 5'd6);
        tick("post_rst");
        check_eq("post_rst_r5", rdata_a[31:0], 32'h0);
        check_eq("post_rst_r6", rdata_b[63:32], 32'h0);
        sweep("rst_sweep");

        // entry 0
        idle();
        wr_a(0, 5'd0, 32'h12345678, 4'hF);
        wr_b(5'd0, 32'h12345678, 4'hF);
        tick("zero_wr");
        idle();
        rd(0, 5'd0);
        tick("zero_rd");
        check_eq("zero_a", rdata_a[31:0], 32'h0);
        check_eq("zero_b", rdata_b[31:0], 32'h12345678);

        // byte enables and bypass
        idle();
        wr_a(0, 5'd3, 32'h11223344, 4'hF);
        wr_b(5'd3, 32'h11223344, 4'hF);
        tick("be_init");
        idle();
        wr_a(0, 5'd3, 32'hAABBCCDD, 4'b0101);
        wr_b(5'd3, 32'hAABBCCDD, 4'b0101);
        rd(0, 5'd3);
        tick("be_byp");
        check_eq("byp_a", rdata_a[31:0], 32'h11BB33DD);
        check_eq("byp_b", rdata_b[31:0], 32'h11223344);
        idle();
        rd(0, 5'd3);
        tick("be_after");
        check_eq("be_after_a", rdata_a[31:0], 32'h11BB33DD);
        check_eq("be_after_b", rdata_b[31:0], 32'h11BB33DD);

        // write conflict on A, resolved per byte
        idle();
        wr_a(0, 5'd7, 32'h00000001, 4'hF);
        wr_a(1, 5'd7, 32'hFFFF0000, 4'b1100);
        rd(1, 5'd7);
        tick("conflict");
        check_eq("conflict_a", rdata_a[63:32], 32'hFFFF0001);
        idle();
        rd(0, 5'd7);
        tick("conflict_rd");
        check_eq("conflict_rd_a", rdata_a[31:0], 32'hFFFF0001);

        // stall hold, then reset while stalled
        idle();
        wr_a(0, 5'd4, 32'h00000055, 4'hF);
        wr_b(5'd4, 32'h00000055, 4'hF);
        tick("stall_init");
        idle();
        rd(0, 5'd4);
        tick("stall_rd");
        for (int c = 0; c < 3; c++) begin
            idle();
            wr_a(0, 5'd4, 32'h00000066, 4'hF);
            wr_b(5'd4, 32'h00000066, 4'hF);
            tick("stall_hold");
            check_eq("hold_a", rdata_a[31:0], 32'h00000055);
            check_eq("hold_b", rdata_b[31:0], 32'h00000055);
        end
        idle();
        rd(0, 5'd4);
        tick("stall_release");
        check_eq("release_a", rdata_a[31:0], 32'h00000066);
        check_eq("release_b", rdata_b[31:0], 32'h00000066);
        idle();
        rst = 1'b0;
        tick("stall_rst");
        check_eq("stall_rst_a", rdata_a[31:0], 32'h0);
        rst = 1'b1;

        // out-of-range on B (DEPTH=24)
        idle();
        wr_a(0, 5'd30, 32'h00000099, 4'hF);
        wr_b(5'd30, 32'h00000099, 4'hF);
        tick("oor_wr");
        idle();
        rd(0, 5'd30);
        tick("oor_rd");
        check_eq("oor_a", rdata_a[31:0], 32'h00000099);
        check_eq("oor_b", rdata_b[31:0], 32'h0);
        sweep("oor_sweep");

        // random traffic with occasional reset
        for (int n = 0; n < 200; n++) begin
            rst = ($urandom_range(0, 39) != 0);
            ren_a = 2'($urandom);
            raddr_a = 10'($urandom);
            wen_a = 2'($urandom);
            waddr_a = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
            if ($urandom_range(0, 3) == 0) waddr_a[9:5] = waddr_a[4:0];
            wdata_a = {$urandom, $urandom};
            wbe_a = 8'($urandom);
            ren_b = 2'($urandom);
            raddr_b = 10'($urandom);
            wen_b = 1'($urandom);
            waddr_b = 5'($urandom);
            wdata_b = $urandom;
            wbe_b = 4'($urandom);
            tick("rand");
        end
        rst = 1'b1;
        sweep("final_sweep");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
